// File: rtl/rr_quota_arbiter.sv
// Round-robin hold arbiter with a per-grant quota; one-cycle registered grant latency,
// at least one all-zero cycle between grants, and preemption only when another agent is waiting.
module rr_quota_arbiter #(
    parameter int N     = 3,
    parameter int QUOTA = 8,
    parameter int IDW   = $clog2(N),
    parameter int CW    = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] QMAX = CW'(QUOTA);

    state_t         state, nxt_state;
    logic [IDW-1:0] owner, nxt_owner;
    logic [IDW-1:0] ptr, nxt_ptr;
    logic [CW-1:0]  hold_cnt, nxt_cnt;
    logic           nxt_preempt;
    logic [IDW-1:0] winner;
    logic [N-1:0]   owner_oh;
    logic [N-1:0]   nxt_gnt;
    logic           competing;

    assign owner_oh  = {{(N-1){1'b0}}, 1'b1} << owner;
    assign competing = |(req & ~owner_oh);

    // Rotating search: first requester at or after ptr, wrapping modulo N.
    always_comb begin
        int  j;
        logic found;
        j      = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_owner   = owner;
        nxt_ptr     = ptr;
        nxt_cnt     = hold_cnt;
        nxt_preempt = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    nxt_state = GRANT;
                    nxt_owner = winner;
                    nxt_cnt   = CW'(1);
                    nxt_ptr   = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
                end
            end
            GRANT: begin
                // Voluntary release takes precedence over quota expiry.
                if (!req[owner]) begin
                    nxt_state = IDLE;
                end else if (competing && (QUOTA != 0) && (hold_cnt == QMAX)) begin
                    nxt_state   = IDLE;
                    nxt_preempt = 1'b1;
                end else if (hold_cnt < QMAX) begin
                    nxt_cnt = hold_cnt + CW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign nxt_gnt = (nxt_state == GRANT) ? ({{(N-1){1'b0}}, 1'b1} << nxt_owner) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
        end else begin
            state     <= nxt_state;
            owner     <= nxt_owner;
            ptr       <= nxt_ptr;
            hold_cnt  <= nxt_cnt;
            gnt       <= nxt_gnt;
            gnt_valid <= (nxt_state == GRANT);
            gnt_id    <= (nxt_state == GRANT) ? nxt_owner : '0;
            preempt   <= nxt_preempt;
        end
    end

endmodule

// File: tb/tb_rr_quota_arbiter.sv
// Directed bench for rr_quota_arbiter: one QUOTA=8 and one QUOTA=4 instance share clock, reset and requests.
module tb_rr_quota_arbiter;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] req    = 3'b000;

    logic [2:0] g8, g4;
    logic       v8, v4;
    logic [1:0] id8, id4;
    logic       p8, p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_quota_arbiter #(.N(3), .QUOTA(8)) u8 (
        .clk(clk), .resetn(resetn), .req(req),
        .gnt(g8), .gnt_valid(v8), .gnt_id(id8), .preempt(p8)
    );

    rr_quota_arbiter #(.N(3), .QUOTA(4)) u4 (
        .clk(clk), .resetn(resetn), .req(req),
        .gnt(g4), .gnt_valid(v4), .gnt_id(id4), .preempt(p4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        int grp;
        int pos;

        // Reset with all requests asserted
        req    = 3'b111;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt8",   8'(g8),  8'h0);
        chk("rst_vld8",   8'(v8),  8'h0);
        chk("rst_id8",    8'(id8), 8'h0);
        chk("rst_pre8",   8'(p8),  8'h0);
        chk("rst_gnt4",   8'(g4),  8'h0);

        resetn = 1'b1;
        tick();
        chk("first_gnt8", 8'(g8),  8'h1);
        chk("first_vld8", 8'(v8),  8'h1);
        chk("first_id8",  8'(id8), 8'h0);
        req = 3'b000;
        tick();
        chk("drop_gnt8",  8'(g8),  8'h0);

        // Solo hold: no competitor, so neither quota ever preempts
        req = 3'b010;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("solo_gnt8", 8'(g8), 8'h2);
            chk("solo_pre8", 8'(p8), 8'h0);
            chk("solo_gnt4", 8'(g4), 8'h2);
            chk("solo_pre4", 8'(p4), 8'h0);
        end
        chk("solo_id8", 8'(id8), 8'h1);
        req = 3'b000;
        tick();
        chk("solo_rel8", 8'(g8), 8'h0);
        chk("solo_rel4", 8'(g4), 8'h0);

        // Contention rotation on the QUOTA=4 instance
        pulse_reset();
        req = 3'b111;
        for (int c = 0; c < 16; c++) begin
            tick();
            grp = (c / 5) % 3;
            pos = c % 5;
            if (pos == 4) begin
                chk("rot_gnt", 8'(g4),  8'h0);
                chk("rot_pre", 8'(p4),  8'h1);
                chk("rot_vld", 8'(v4),  8'h0);
            end else begin
                chk("rot_gnt", 8'(g4),  8'(1 << grp));
                chk("rot_pre", 8'(p4),  8'h0);
                chk("rot_id",  8'(id4), 8'(grp));
            end
        end
        req = 3'b000;
        tick();

        // Voluntary release while req2 waits
        pulse_reset();
        req = 3'b101;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("vol_gnt", 8'(g4), 8'h1);
            chk("vol_pre", 8'(p4), 8'h0);
        end
        req = 3'b100;
        tick();
        chk("vol_gap",     8'(g4),  8'h0);
        chk("vol_gap_pre", 8'(p4),  8'h0);
        tick();
        chk("vol_next",    8'(g4),  8'h4);
        chk("vol_next_id", 8'(id4), 8'h2);
        chk("vol_next_pr", 8'(p4),  8'h0);
        req = 3'b000;
        tick();

        // Release coinciding with quota expiry: release wins
        req = 3'b011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("qe_gnt", 8'(g4), 8'h1);
        end
        req = 3'b010;
        tick();
        chk("qe_gap",     8'(g4),  8'h0);
        chk("qe_gap_pre", 8'(p4),  8'h0);
        tick();
        chk("qe_next",    8'(g4),  8'h2);
        chk("qe_next_id", 8'(id4), 8'h1);
        req = 3'b000;
        tick();

        // Asynchronous reset in the middle of a grant
        req = 3'b100;
        tick();
        chk("mr_pre_gnt", 8'(g4),  8'h4);
        chk("mr_pre_id",  8'(id4), 8'h2);
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_gnt4", 8'(g4),  8'h0);
        chk("mr_vld4", 8'(v4),  8'h0);
        chk("mr_id4",  8'(id4), 8'h0);
        chk("mr_pre4", 8'(p4),  8'h0);
        chk("mr_gnt8", 8'(g8),  8'h0);
        req = 3'b101;
        #2;
        resetn = 1'b1;
        tick();
        chk("mr_after_gnt", 8'(g4),  8'h1);
        chk("mr_after_id",  8'(id4), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
